uart_tx_scheduler: RTL and testbench

Shares the single uart_tx byte transmitter among several message requesters: echo, status, config readback and gesture report. Each requester posts a 1- or 2-byte message. The scheduler arbitrates between them, then sequences each message byte by byte using the transmitter's busy handshake. This replaces the ad-hoc TX state machine in the top-level command handler.

---
 rtl/uart_tx_sched_pkg.sv | 24 ++
 rtl/tx_req_arbiter.sv | 74 +++++++
 rtl/uart_tx_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_sched_pkg
// Shared types and helpers for the UART TX scheduler slice:
//   state_e   - scheduler FSM states
//   BYTE0/1   - byte index values inside a two-byte message
//   grant_w() - width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } state_e;

  localparam logic BYTE0 = 1'b0;
  localparam logic BYTE1 = 1'b1;

  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/tx_req_arbiter.sv
// -----------------------------------------------------------------------------
// tx_req_arbiter
// Picks one requester out of req and reports it both one-hot and as an index.
//   clk, rst   - clock, synchronous active-high reset (pointer only)
//   req        - pending requests
//   advance    - a grant was taken this cycle (moves the round-robin pointer)
//   grant_oh   - one-hot winner (all zero when no request)
//   grant_idx  - winner index (0 when no request)
// Build option UART_TX_SCHED_RR_EN: round-robin search starting one past the
// last taken grant. Without it, fixed priority (lowest index wins) and no
// pointer register is built.
// -----------------------------------------------------------------------------
module tx_req_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic                          advance,
  output logic [NUM_REQ-1:0]            grant_oh,
  output logic [grant_w(NUM_REQ)-1:0]   grant_idx
);

  localparam int GW = grant_w(NUM_REQ);

  logic [GW-1:0] start_idx;
  logic [GW-1:0] idx;
  logic          found;

`ifdef UART_TX_SCHED_RR_EN
  logic [GW-1:0] ptr_q, ptr_d;

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + GW'(1);
    end
  end

  assign start_idx = ptr_q;
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, advance};
  assign start_idx = '0;
`endif

  // Walk the requests starting at start_idx, wrapping at NUM_REQ-1.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = GW'((int'(start_idx) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one uart_tx byte transmitter between NUM_REQ message requesters.
// Each requester posts a 1- or 2-byte message; one is accepted per IDLE visit
// and sent byte by byte using the transmitter's busy handshake.
//   clk, rst     - clock, synchronous active-high reset
//   req_valid    - per-requester message pending (held until accepted)
//   req_two_byte - per-requester length: 1 = two bytes, 0 = one byte
//   req_data     - slot i at [16i+15:16i]; byte0 = [15:8], byte1 = [7:0]
//   req_ready    - one-hot accept, combinational, only while IDLE
//   tx_data      - byte presented to uart_tx
//   tx_valid     - one-cycle start pulse to uart_tx
//   tx_busy      - uart_tx busy
//   grant_id     - index of the last accepted requester
//   sched_busy   - a message is in flight
//   msg_count    - messages fully sent, wraps
// Build option UART_TX_SCHED_RR_EN selects round-robin arbitration (see
// tx_req_arbiter); default is fixed priority, index 0 highest.
// -----------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 8,
  parameter int CNT_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_two_byte,
  input  logic [16*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       sched_busy,
  output logic [CNT_W-1:0]           msg_count
);

  localparam int GW = grant_w(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [15:0]    data_q, data_d;
  logic           two_q, two_d;
  logic           idx_q, idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic           busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [GW-1:0]      win_idx;
  logic               accept;
  logic [15:0]        sel_data;
  logic               sel_two;
  logic [7:0]         cur_byte;

  tx_req_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant_oh  (win_oh),
    .grant_idx (win_idx)
  );

  // The arbiter only ever selects a valid request, so any ready bit is a
  // transfer. Held low during reset so nothing is offered to requesters.
  assign req_ready = (state_q == IDLE && !rst) ? win_oh : '0;
  assign accept    = |req_ready;

  always_comb begin
    sel_data = '0;
    sel_two  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == GW'(i)) begin
        sel_data = req_data[16*i +: 16];
        sel_two  = req_two_byte[i];
      end
    end
  end

  assign cur_byte = (idx_q == BYTE0) ? data_q[15:8] : data_q[7:0];

  // State register and control flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
    end
  end

  // NOTE: message payload, byte index and timeout counter are left unreset:
  // each is loaded before the FSM can read it, so reset would only add fanout.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    two_q  <= two_d;
    idx_q  <= idx_d;
    tmo_q  <= tmo_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept) state_d = SEND;
      SEND:      if (!tx_busy) state_d = WAIT_RISE;
      // A transmitter that never raises busy is treated as having sent the
      // byte once the timeout counter reaches BUSY_TIMEOUT.
      WAIT_RISE: if (tx_busy || tmo_q == TW'(BUSY_TIMEOUT)) state_d = WAIT_FALL;
      WAIT_FALL: if (!tx_busy) state_d = (two_q && idx_q == BYTE0) ? SEND : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    data_d     = data_q;
    two_d      = two_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    grant_d    = grant_q;
    busy_d     = busy_q;
    count_d    = count_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = sel_data;
          two_d   = sel_two;
          grant_d = win_idx;
          busy_d  = 1'b1;
          idx_d   = BYTE0;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_d  = cur_byte;
          tx_valid_d = 1'b1;
          tmo_d      = TW'(1);
        end
      end
      WAIT_RISE: begin
        if (!tx_busy && tmo_q != TW'(BUSY_TIMEOUT)) tmo_d = tmo_q + TW'(1);
      end
      WAIT_FALL: begin
        if (!tx_busy) begin
          if (two_q && idx_q == BYTE0) begin
            idx_d = BYTE1;
          end else begin
            count_d = count_q + CNT_W'(1);
            busy_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign grant_id   = grant_q;
  assign sched_busy = busy_q;
  assign msg_count  = count_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench for uart_tx_scheduler: a table of single-requester
// messages, hand sequences for arbitration order, busy held at accept and
// reset mid-message, then randomized request mixes checked against a model.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 8;
  localparam int CNT_W        = 8;
  localparam int BUSY_LEN     = 3;   // cycles the modelled uart_tx stays busy

  typedef enum int {M_UART, M_ZERO, M_HIGH} busy_mode_e;
  typedef struct { int cyc; logic [7:0] data; } pulse_t;
  typedef struct {
    int          req;
    bit          two;
    logic [15:0] data;
    busy_mode_e  mode;
    int          nbytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_two_byte;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_busy;
  logic [1:0]            grant_id;
  logic                  sched_busy;
  logic [CNT_W-1:0]      msg_count;

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_two_byte(req_two_byte),
    .req_data(req_data), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_busy(tx_busy), .grant_id(grant_id),
    .sched_busy(sched_busy), .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ready_pulses = 0;
  pulse_t txq[$];
  busy_mode_e bmode = M_UART;
  int busy_left = 0;
  int exp_count = 0;
  int exp_ptr   = 0;

  initial forever begin @(posedge clk); cyc++; end

  // Monitor: every tx_valid cycle and every req_ready cycle, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (tx_valid) txq.push_back('{cyc, tx_data});
    if (|req_ready) ready_pulses++;
  end

  // uart_tx model: busy rises the cycle after tx_valid and lasts BUSY_LEN.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (bmode)
        M_UART: begin
          if (busy_left > 0) begin tx_busy = 1'b1; busy_left--; end
          else tx_busy = 1'b0;
          if (tx_valid) busy_left = BUSY_LEN;
        end
        M_ZERO:  begin tx_busy = 1'b0; busy_left = 0; end
        default: tx_busy = 1'b1;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Arbitration rule: first pending index at or after the start point.
  function automatic int ref_pick(input logic [NUM_REQ-1:0] pend);
    int start = 0;
`ifdef UART_TX_SCHED_RR_EN
    start = exp_ptr;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      int j = (start + k) % NUM_REQ;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_accept(input int j);
    exp_ptr = (j + 1) % NUM_REQ;
  endfunction

  // Expected pulse cycles and the first idle cycle for a message accepted in
  // cycle n. With the uart model, busy is high p+1..p+L after a pulse at p and
  // is seen low at p+L+1. With busy tied low, the FSM spends BUSY_TIMEOUT
  // cycles waiting for a rise, starting in the pulse cycle.
  task automatic model_times(input int n, input int nb, input busy_mode_e m,
                             output int p0, output int p1, output int done);
    p0 = n + 2;
    if (m == M_UART) begin
      p1   = p0 + BUSY_LEN + 3;
      done = ((nb == 2) ? p1 : p0) + BUSY_LEN + 2;
    end else begin
      p1   = p0 + BUSY_TIMEOUT + 2;
      done = ((nb == 2) ? p1 : p0) + BUSY_TIMEOUT + 1;
    end
  endtask

  task automatic wait_ready(input string tag, output int idx);
    bit seen = 0;
    idx = -1;
    #1;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (|req_ready) seen = 1;
      else step();
    end
    if (!seen) check({tag, "_ready_timeout"}, 0, 1);
    else for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
  endtask

  task automatic wait_idle(input string tag, output int done);
    bit idle = 0;
    for (int k = 0; k < 300 && !idle; k++) begin
      if (!sched_busy) idle = 1;
      else step();
    end
    if (!idle) check({tag, "_idle_timeout"}, 0, 1);
    done = cyc;
  endtask

  task automatic send_one(input string tag, input vec_t v);
    int base, rp, acc, idx, p0, p1, done, edone;
    bmode = v.mode;
    base  = txq.size();
    rp    = ready_pulses;
    req_data[16*v.req +: 16] = v.data;
    req_two_byte[v.req]      = v.two;
    req_valid[v.req]         = 1'b1;
    wait_ready(tag, idx);
    acc = cyc;
    check({tag, "_winner"}, idx, v.req);
    step();
    req_valid[v.req]         = 1'b0;
    req_data[16*v.req +: 16] = 16'($urandom);
    req_two_byte[v.req]      = ~v.two;
    model_accept(v.req);
    check({tag, "_grant_id"}, grant_id, v.req);
    check({tag, "_sched_busy"}, sched_busy, 1);
    wait_idle(tag, done);
    exp_count = (exp_count + 1) % (1 << CNT_W);
    model_times(acc, v.nbytes, v.mode, p0, p1, edone);
    check({tag, "_n_bytes"}, txq.size() - base, v.nbytes);
    if (txq.size() - base >= 1) begin
      check({tag, "_byte0"}, txq[base].data, v.b0);
      check({tag, "_byte0_cycle"}, txq[base].cyc, p0);
    end
    if (v.nbytes == 2 && txq.size() - base >= 2) begin
      check({tag, "_byte1"}, txq[base+1].data, v.b1);
      check({tag, "_byte1_cycle"}, txq[base+1].cyc, p1);
    end
    check({tag, "_done_cycle"}, done, edone);
    check({tag, "_msg_count"}, msg_count, exp_count);
    check({tag, "_ready_pulses"}, ready_pulses - rp, 1);
  endtask

  initial begin
    vec_t vt[5];
    int base, idx, exp, acc, done, edone, x, last_done;
    logic [NUM_REQ-1:0] pend;
    logic [7:0] expq[$];
    logic [15:0] sd[NUM_REQ];
    bit st[NUM_REQ];

    vt[0] = '{1, 0, 16'h5500, M_UART, 1, 8'h55, 8'h00};
    vt[1] = '{3, 1, 16'hA27C, M_UART, 2, 8'hA2, 8'h7C};
    vt[2] = '{0, 0, 16'h1234, M_ZERO, 1, 8'h12, 8'h00};
    vt[3] = '{2, 1, 16'hBEEF, M_ZERO, 2, 8'hBE, 8'hEF};
    vt[4] = '{0, 1, 16'h0F0E, M_UART, 2, 8'h0F, 8'h0E};

    // Reset, with a request already pending.
    rst = 1'b1; req_valid = '0; req_two_byte = '0; req_data = '0;
    req_valid[0] = 1'b1;
    repeat (3) step();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_sched_busy", sched_busy, 0);
    check("rst_msg_count", msg_count, 0);
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) send_one($sformatf("vec%0d", i), vt[i]);

    // Requesters 0 and 2 together; both stay valid until accepted.
    bmode = M_UART;
    base  = txq.size();
    req_data[15:0]  = 16'h1100;
    req_data[47:32] = 16'h2200;
    req_two_byte    = '0;
    req_valid       = 4'b0101;
    pend            = 4'b0101;
    for (int r = 0; r < 2; r++) begin
      exp = ref_pick(pend);
      wait_ready($sformatf("sim%0d", r), idx);
      check($sformatf("sim%0d_winner", r), idx, exp);
      check($sformatf("sim%0d_onehot", r), $countones(req_ready), 1);
      step();
      if (idx >= 0) req_valid[idx] = 1'b0;
      pend[exp] = 1'b0;
      model_accept(exp);
      expq.push_back((exp == 0) ? 8'h11 : 8'h22);
      check($sformatf("sim%0d_grant_id", r), grant_id, exp);
      wait_idle("sim", done);
      exp_count = (exp_count + 1) % (1 << CNT_W);
    end
    check("sim_n_bytes", txq.size() - base, 2);
    for (int k = 0; k < 2; k++)
      if (base + k < txq.size()) check($sformatf("sim_order%0d", k), txq[base+k].data, expq[k]);
    check("sim_msg_count", msg_count, exp_count);
    req_valid = '0;
    expq.delete();

    // tx_busy already high at accept: SEND must hold until it drops.
    bmode = M_HIGH;
    step();
    base = txq.size();
    req_data[47:32] = 16'h3C00; req_two_byte[2] = 1'b0; req_valid[2] = 1'b1;
    wait_ready("hold", idx);
    check("hold_winner", idx, 2);
    step();
    req_valid[2] = 1'b0;
    model_accept(2);
    repeat (6) step();
    check("hold_no_pulse", txq.size() - base, 0);
    check("hold_sched_busy", sched_busy, 1);
    bmode = M_UART;
    x = cyc;
    wait_idle("hold", done);
    exp_count = (exp_count + 1) % (1 << CNT_W);
    check("hold_n_bytes", txq.size() - base, 1);
    if (txq.size() > base) begin
      check("hold_byte", txq[base].data, 8'h3C);
      check("hold_pulse_cycle", txq[base].cyc, x + 1);
    end
    check("hold_done_cycle", done, x + 1 + BUSY_LEN + 2);
    check("hold_msg_count", msg_count, exp_count);

    // Reset after byte0 of a two-byte message.
    base = txq.size();
    req_data[63:48] = 16'hC35A; req_two_byte[3] = 1'b1; req_valid[3] = 1'b1;
    wait_ready("mid", idx);
    step();
    req_valid[3] = 1'b0;
    for (int k = 0; k < 50 && txq.size() == base; k++) step();
    check("mid_byte0_sent", txq.size() - base, 1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 0;
    exp_ptr   = 0;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_sched_busy", sched_busy, 0);
    check("mid_rst_msg_count", msg_count, 0);
    check("mid_rst_grant_id", grant_id, 0);
    repeat (30) step();
    check("mid_no_byte1", txq.size() - base, 1);
    send_one("post_rst", '{1, 0, 16'h9900, M_UART, 1, 8'h99, 8'h00});

    // Random request mixes against the model.
    base = txq.size();
    for (int r = 0; r < 25; r++) begin
      bmode = ($urandom_range(0, 1) == 0) ? M_UART : M_ZERO;
      pend  = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        sd[i] = 16'($urandom);
        st[i] = 1'($urandom);
        req_data[16*i +: 16] = sd[i];
        req_two_byte[i]      = st[i];
      end
      req_valid = pend;
      last_done = -1;
      while (pend != '0) begin
        exp = ref_pick(pend);
        wait_ready($sformatf("rnd%0d", r), idx);
        acc = cyc;
        check($sformatf("rnd%0d_winner", r), idx, exp);
        if (idx < 0) break;
        if (last_done >= 0) check($sformatf("rnd%0d_back_to_back", r), acc, last_done);
        step();
        req_valid[idx]         = 1'b0;
        req_data[16*idx +: 16] = 16'($urandom);
        req_two_byte[idx]      = ~st[idx];
        pend[idx] = 1'b0;
        model_accept(idx);
        check($sformatf("rnd%0d_grant_id", r), grant_id, idx);
        expq.push_back(sd[idx][15:8]);
        if (st[idx]) expq.push_back(sd[idx][7:0]);
        wait_idle("rnd", done);
        model_times(acc, st[idx] ? 2 : 1, bmode, x, edone, edone);
        check($sformatf("rnd%0d_done_cycle", r), done, edone);
        last_done = done;
        exp_count = (exp_count + 1) % (1 << CNT_W);
      end
      req_valid = '0;
      check($sformatf("rnd%0d_msg_count", r), msg_count, exp_count);
    end
    check("rnd_n_bytes", txq.size() - base, expq.size());
    for (int k = 0; k < expq.size(); k++)
      if (base + k < txq.size()) check($sformatf("rnd_byte%0d", k), txq[base+k].data, expq[k]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
